// File: rtl/hazard_ctrl.sv
// Issue-stage hazard control: per-register pending-result scoreboard, stall/flush generation
// for the ISSUE->EXECUTE register, and a saturating stall-cycle counter.
module hazard_ctrl #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned LAT_W    = 2,
    parameter int unsigned PERF_W   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        iss_valid,
    input  logic [$clog2(NUM_REGS)-1:0] iss_rs1_addr,
    input  logic [$clog2(NUM_REGS)-1:0] iss_rs2_addr,
    input  logic                        iss_use_rs1,
    input  logic                        iss_use_rs2,
    input  logic [$clog2(NUM_REGS)-1:0] iss_rd_addr,
    input  logic                        iss_we,
    input  logic [LAT_W-1:0]            iss_lat,
    input  logic                        ex_busy,
    input  logic                        redirect,
    output logic                        stall,
    output logic                        flush,
    output logic [NUM_REGS-1:0]         sb_pending,
    output logic [PERF_W-1:0]           stall_cycles
);

    localparam int unsigned AW = $clog2(NUM_REGS);

    logic [LAT_W-1:0]  cnt_q [NUM_REGS];
    logic [LAT_W-1:0]  cnt_d [NUM_REGS];
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

    logic raw1, raw2, waw, hazard, fire;

    // Register 0 is hardwired zero, so its address never creates a dependency.
    always_comb begin
        raw1   = iss_use_rs1 && (iss_rs1_addr != AW'(0)) && (cnt_q[iss_rs1_addr] != '0);
        raw2   = iss_use_rs2 && (iss_rs2_addr != AW'(0)) && (cnt_q[iss_rs2_addr] != '0);
        waw    = iss_we && (iss_rd_addr != AW'(0)) && (cnt_q[iss_rd_addr] != '0);
        hazard = iss_valid && (raw1 || raw2 || waw);
    end

    // Redirect wins over every stall source; both controls are quiet during reset.
    always_comb begin
        flush = !rst && redirect;
        stall = !rst && !redirect && (ex_busy || hazard);
    end

    // Single-cycle results are covered by forwarding and are never recorded.
    always_comb begin
        fire = iss_valid && !stall && !redirect && iss_we &&
               (iss_rd_addr != AW'(0)) && (iss_lat != '0);
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (!ex_busy && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - LAT_W'(1);
            end
        end
        if (fire) begin
            cnt_d[iss_rd_addr] = iss_lat;
        end
        cnt_d[0] = '0;
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != {PERF_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cycles_q <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            sb_pending[r] = (cnt_q[r] != '0);
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; built with a 4-bit stall counter so saturation is reachable.
module tb_hazard_ctrl;

    localparam int unsigned PW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [3:0]  iss_rs1_addr, iss_rs2_addr, iss_rd_addr;
    logic        iss_use_rs1, iss_use_rs2, iss_we;
    logic [1:0]  iss_lat;
    logic        ex_busy, redirect;
    logic        stall, flush;
    logic [15:0] sb_pending;
    logic [PW-1:0] stall_cycles;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .NUM_REGS(16),
        .LAT_W   (2),
        .PERF_W  (PW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .iss_valid   (iss_valid),
        .iss_rs1_addr(iss_rs1_addr),
        .iss_rs2_addr(iss_rs2_addr),
        .iss_use_rs1 (iss_use_rs1),
        .iss_use_rs2 (iss_use_rs2),
        .iss_rd_addr (iss_rd_addr),
        .iss_we      (iss_we),
        .iss_lat     (iss_lat),
        .ex_busy     (ex_busy),
        .redirect    (redirect),
        .stall       (stall),
        .flush       (flush),
        .sb_pending  (sb_pending),
        .stall_cycles(stall_cycles)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [3:0] rs1, input logic u1,
                       input logic [3:0] rs2, input logic u2,
                       input logic [3:0] rd, input logic we, input logic [1:0] lat);
        iss_valid    = v;
        iss_rs1_addr = rs1;
        iss_use_rs1  = u1;
        iss_rs2_addr = rs2;
        iss_use_rs2  = u2;
        iss_rd_addr  = rd;
        iss_we       = we;
        iss_lat      = lat;
    endtask

    task automatic idle();
        drv(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 2'd0);
    endtask

    // Inputs change just after posedge; outputs are sampled at negedge.
    task automatic mid();
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        idle();
        ex_busy  = 1'b1;
        redirect = 1'b1;
        mid();
        check_eq("rst_stall_gated", {31'd0, stall}, 32'd0);
        check_eq("rst_flush_gated", {31'd0, flush}, 32'd0);
        tick();
        rst      = 1'b0;
        ex_busy  = 1'b0;
        redirect = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        ex_busy = 1'b0;
        redirect = 1'b0;
        idle();
        #1;
        do_reset();

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            mid();
            check_eq("idle_stall", {31'd0, stall}, 32'd0);
            check_eq("idle_flush", {31'd0, flush}, 32'd0);
            check_eq("idle_sb", {16'd0, sb_pending}, 32'd0);
            check_eq("idle_perf", {28'd0, stall_cycles}, 32'd0);
            tick();
        end

        // RAW, lat=2: reader stalls two cycles
        drv(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 2'd2);
        mid();
        check_eq("raw_c0_stall", {31'd0, stall}, 32'd0);
        tick();
        drv(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 2'd0);
        mid();
        check_eq("raw_c1_stall", {31'd0, stall}, 32'd1);
        check_eq("raw_c1_sb", {16'd0, sb_pending}, 32'h0008);
        tick();
        mid();
        check_eq("raw_c2_stall", {31'd0, stall}, 32'd1);
        check_eq("raw_c2_sb", {16'd0, sb_pending}, 32'h0008);
        tick();
        mid();
        check_eq("raw_c3_stall", {31'd0, stall}, 32'd0);
        check_eq("raw_c3_sb", {16'd0, sb_pending}, 32'h0000);
        check_eq("raw_perf", {28'd0, stall_cycles}, 32'd2);
        tick();
        idle();

        // Zero-latency producer is forwarded
        do_reset();
        drv(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 2'd0);
        mid();
        check_eq("fwd_c0_stall", {31'd0, stall}, 32'd0);
        tick();
        drv(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 2'd0);
        mid();
        check_eq("fwd_c1_stall", {31'd0, stall}, 32'd0);
        check_eq("fwd_c1_sb", {16'd0, sb_pending}, 32'd0);
        tick();
        idle();

        // WAW on r4: second writer waits for cnt[4] to drain
        do_reset();
        drv(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 2'd3);
        tick();
        drv(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 2'd1);
        for (int i = 0; i < 3; i++) begin
            mid();
            check_eq("waw_stall", {31'd0, stall}, 32'd1);
            tick();
        end
        mid();
        check_eq("waw_release", {31'd0, stall}, 32'd0);
        check_eq("waw_perf", {28'd0, stall_cycles}, 32'd3);
        tick();
        idle();
        mid();
        check_eq("waw_second_recorded", {16'd0, sb_pending}, 32'h0010);
        tick();

        // r0 writes and reads are ignored
        do_reset();
        drv(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 2'd3);
        tick();
        drv(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 2'd0);
        mid();
        check_eq("r0_stall", {31'd0, stall}, 32'd0);
        check_eq("r0_sb", {16'd0, sb_pending}, 32'd0);
        tick();
        idle();

        // ex_busy freeze: lat=1 producer, 3 busy cycles, reader via rs2
        do_reset();
        drv(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 2'd1);
        tick();
        drv(1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 4'd0, 1'b0, 2'd0);
        ex_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            check_eq("busy_stall", {31'd0, stall}, 32'd1);
            check_eq("busy_sb_hold", {16'd0, sb_pending}, 32'h0080);
            tick();
        end
        ex_busy = 1'b0;
        mid();
        check_eq("busy_raw_stall", {31'd0, stall}, 32'd1);
        check_eq("busy_raw_sb", {16'd0, sb_pending}, 32'h0080);
        tick();
        mid();
        check_eq("busy_release", {31'd0, stall}, 32'd0);
        check_eq("busy_perf", {28'd0, stall_cycles}, 32'd4);
        tick();
        idle();

        // Redirect priority and squashed write
        do_reset();
        drv(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 2'd3);
        tick();
        drv(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 2'd0);
        ex_busy = 1'b1;
        mid();
        check_eq("redir_pre_stall", {31'd0, stall}, 32'd1);
        check_eq("redir_pre_flush", {31'd0, flush}, 32'd0);
        tick();
        drv(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 2'd3);
        redirect = 1'b1;
        mid();
        check_eq("redir_flush", {31'd0, flush}, 32'd1);
        check_eq("redir_stall", {31'd0, stall}, 32'd0);
        tick();
        redirect = 1'b0;
        ex_busy  = 1'b0;
        idle();
        mid();
        check_eq("redir_sb", {16'd0, sb_pending}, 32'h0004);
        check_eq("redir_flush_off", {31'd0, flush}, 32'd0);
        tick();

        // Reset mid-operation discards pending counts
        do_reset();
        drv(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 2'd3);
        tick();
        idle();
        mid();
        check_eq("mrst_pre_sb", {16'd0, sb_pending}, 32'h0040);
        do_reset();
        drv(1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 2'd0);
        mid();
        check_eq("mrst_stall", {31'd0, stall}, 32'd0);
        check_eq("mrst_sb", {16'd0, sb_pending}, 32'd0);
        tick();
        idle();

        // Counter saturation
        do_reset();
        ex_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 9) begin
                check_eq("perf_mid", {28'd0, stall_cycles}, 32'd10);
            end
        end
        ex_busy = 1'b0;
        mid();
        check_eq("perf_sat", {28'd0, stall_cycles}, 32'd15);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Control-side counterpart of the ISSUE->EXECUTE pipeline register: generates the `stall` and `flush` controls that register consumes.
- Keeps a per-register scoreboard of in-flight multi-cycle results. Stalls ISSUE on RAW/WAW hazards, or while EXECUTE is busy.
- Flushes on a control-flow redirect.
- Exposes a saturating stall-cycle performance counter.

Parameters:
- NUM_REGS, 16, architectural register count (4-bit addresses); register 0 is hardwired zero.
- LAT_W, 2, width of the latency class; max extra latency is 2^LAT_W-1 = 3.
- PERF_W, 32, width of the stall-cycle counter.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset, synchronous, active-high.
- iss_valid, input, 1, ISSUE holds a valid instruction.
- iss_rs1_addr, input, 4, source 1 register.
- iss_rs2_addr, input, 4, source 2 register.
- iss_use_rs1, input, 1, instruction reads rs1.
- iss_use_rs2, input, 1, instruction reads rs2.
- iss_rd_addr, input, 4, destination register.
- iss_we, input, 1, instruction writes rd.
- iss_lat, input, LAT_W, extra cycles before the result is forwardable; 0 means a single-cycle ALU op.
- ex_busy, input, 1, EXECUTE is holding (iterative unit); pipeline frozen.
- redirect, input, 1, branch/exception redirect resolved this cycle.
- stall, output, 1, hold ISSUE->EXECUTE register and upstream stages.
- flush, output, 1, squash the ISSUE->EXECUTE register.
- sb_pending, output, NUM_REGS, bit r = register r has a pending result.
- stall_cycles, output, PERF_W, count of cycles with stall=1.

Behaviour:
- State:
  - cnt[r], LAT_W bits, r = 1..NUM_REGS-1; cnt[0] is constant 0.
  - perf counter.
- Reset (rst=1 at posedge): all cnt = 0; stall_cycles = 0.
- While rst=1: stall=0 and flush=0, combinationally.
- sb_pending[r] = (cnt[r] != 0). It is registered-state derived, so sb_pending = 0 the cycle after reset.
- Hazard terms (combinational, same cycle):
  - raw1 = iss_use_rs1 & (rs1 != 0) & cnt[rs1] != 0.
  - raw2 = iss_use_rs2 & (rs2 != 0) & cnt[rs2] != 0.
  - waw = iss_we & (rd != 0) & cnt[rd] != 0.
  - hazard = iss_valid & (raw1 | raw2 | waw).
- Outputs (combinational, zero latency):
  - flush = redirect.
  - stall = ~redirect & (ex_busy | hazard).
  - Redirect has priority: redirect=1 forces flush=1 and stall=0, even when ex_busy=1.
- fire = iss_valid & ~stall & ~redirect & iss_we & (rd != 0) & (iss_lat != 0).
- Scoreboard update at each posedge (not rst):
  - ex_busy=1: every cnt holds; no fire is possible because stall=1.
  - else, each r with cnt[r] != 0: cnt[r] <= cnt[r]-1.
  - if fire: cnt[rd] <= iss_lat, overriding any decrement; waw guarantees cnt[rd] was 0.
  - redirect does not clear existing counts: older in-flight instructions complete. Only the squashed instruction is not recorded.
- Instructions with iss_lat=0 never stall dependents; the forwarding network covers them.
- Dependent timing: after a fire with iss_lat=L at cycle t, a reader of rd stalls in cycles t+1 .. t+L and issues in t+L+1, provided no ex_busy cycles intervene. Each ex_busy cycle extends this by one.
- stall_cycles:
  - increments by 1 at each posedge where stall=1.
  - saturates at all-ones; no wrap.
- Reads of register 0 and writes to register 0 never cause hazards and never set the scoreboard.
- Reset mid-operation: all pending counts discarded immediately; no stall the cycle after rst deasserts.

Test Plan:
- Reset then idle (iss_valid=0) 5 cycles:
  - stall=0, flush=0, sb_pending=0, stall_cycles=0.
- RAW, short latency:
  - Cycle 0: issue rd=3, iss_lat=2.
  - Cycle 1: rs1=3, use_rs1=1.
  - Required: stall=1 in cycles 1 and 2; stall=0 in cycle 3.
  - sb_pending[3]=1 in cycles 1-2; stall_cycles=2.
- Forwardable result: issue rd=5, iss_lat=0, then reader of r5 next cycle -> stall never asserts; sb_pending stays 0.
- WAW and r0:
  - Issue rd=4, lat=3; next cycle issue a write to rd=4 with lat=1 -> stall until cnt[4]=0, 3 cycles.
  - Separately, issue rd=0, lat=3, then a reader of r0 -> no stall, sb_pending[0]=0.
- ex_busy freeze:
  - Issue rd=7, lat=1; then assert ex_busy for 3 cycles with a reader of r7 waiting.
  - Required: stall=1 for 4 cycles total; cnt[7] holds at 1 during ex_busy.
- Redirect priority:
  - Hold a RAW stall on r2 with ex_busy=1, then pulse redirect for 1 cycle -> that cycle flush=1 and stall=0.
  - A squashed write (rd=9, lat=3) issued in the redirect cycle leaves sb_pending[9]=0.
- Counter saturation (bench with PERF_W=4): hold ex_busy=1 for 20 cycles -> stall_cycles stops at 15.
